// File: rtl/audio_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | audio_pkg                                                                  |
// | Shared note codes, envelope state encoding and default widths.             |
// | Optional macro: PLUCK_ENVELOPE_SUSTAIN_EN adds the SUSTAIN state.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package audio_pkg;

   localparam int c_amp_w_default = 8;

   localparam logic [2:0] NOTE_A    = 3'd0;
   localparam logic [2:0] NOTE_B    = 3'd1;
   localparam logic [2:0] NOTE_C    = 3'd2;
   localparam logic [2:0] NOTE_D    = 3'd3;
   localparam logic [2:0] NOTE_E    = 3'd4;
   localparam logic [2:0] NOTE_F    = 3'd5;
   localparam logic [2:0] NOTE_G    = 3'd6;
   localparam logic [2:0] NOTE_NONE = 3'd7;

`ifdef PLUCK_ENVELOPE_SUSTAIN_EN
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ATTACK  = 3'd1,
      ST_DECAY   = 3'd2,
      ST_MUTE    = 3'd3,
      ST_SUSTAIN = 3'd4
   } env_state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ATTACK  = 3'd1,
      ST_DECAY   = 3'd2,
      ST_MUTE    = 3'd3
   } env_state_t;
`endif

endpackage
`default_nettype wire

// File: rtl/env_prescaler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | env_prescaler                                                              |
// | Envelope step divider: tick when count == div-1, then wrap to 0.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module env_prescaler #(
   parameter int CNT_W = 18
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic [CNT_W-1:0] div,
   output logic             tick
);

   localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

   logic [CNT_W-1:0] r_count;

   assign tick = (r_count == (div - c_one));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (clear || tick) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + c_one;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pluck_envelope.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pluck_envelope                                                             |
// | Attack/decay/mute pluck envelope applied to a square wave by PWM gating.   |
// | Optional macro: PLUCK_ENVELOPE_SUSTAIN_EN (decay holds at SUSTAIN_LEVEL).  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pluck_envelope
   import audio_pkg::*;
#(
   parameter int AMP_W       = c_amp_w_default,
   parameter int ATTACK_DIV  = 50000,
   parameter int ATTACK_STEP = 64,
   parameter int DECAY_DIV   = 195312,
   parameter int MUTE_DIV    = 5000
`ifdef PLUCK_ENVELOPE_SUSTAIN_EN
   ,
   parameter int SUSTAIN_LEVEL = 64
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wave_in,
   input  logic [2:0]       note_code,
   input  logic             pluck,
   output logic             audio_out,
   output logic [AMP_W-1:0] amplitude,
   output logic             active
);

   localparam int c_max_ad  = (ATTACK_DIV > DECAY_DIV) ? ATTACK_DIV : DECAY_DIV;
   localparam int c_max_div = (c_max_ad > MUTE_DIV) ? c_max_ad : MUTE_DIV;
   localparam int CNT_W     = $clog2(c_max_div + 1);

   localparam logic [CNT_W-1:0] c_attack_div = CNT_W'(ATTACK_DIV);
   localparam logic [CNT_W-1:0] c_decay_div  = CNT_W'(DECAY_DIV);
   localparam logic [CNT_W-1:0] c_mute_div   = CNT_W'(MUTE_DIV);
   localparam logic [AMP_W-1:0] c_amp_max    = {AMP_W{1'b1}};
   localparam logic [AMP_W-1:0] c_amp_one    = AMP_W'(1);
   localparam logic [AMP_W:0]   c_step       = (AMP_W+1)'(ATTACK_STEP);
`ifdef PLUCK_ENVELOPE_SUSTAIN_EN
   localparam logic [AMP_W-1:0] c_sustain    = AMP_W'(SUSTAIN_LEVEL);
`endif

   env_state_t       r_state;
   logic [AMP_W-1:0] r_amp;
   logic [AMP_W-1:0] r_pwm_cnt;
   logic             r_audio;
   logic             r_active;

   logic             w_pluck_ok;
   logic             w_to_mute;
   logic             w_clear;
   logic             w_tick;
   logic [CNT_W-1:0] w_div;
   logic [AMP_W:0]   w_sum;
   logic [AMP_W-1:0] w_attack_amp;

   assign amplitude = r_amp;
   assign active    = r_active;
   assign audio_out = r_audio;

   always_comb begin
      w_pluck_ok   = pluck && (note_code != NOTE_NONE);
      w_to_mute    = (r_state != ST_IDLE) && (r_state != ST_MUTE) && (note_code == NOTE_NONE);
      // Entries on a tick need no clear: the prescaler wraps to 0 by itself.
      w_clear      = w_pluck_ok || w_to_mute || (r_state == ST_IDLE);
      w_sum        = {1'b0, r_amp} + c_step;
      w_attack_amp = (w_sum > {1'b0, c_amp_max}) ? c_amp_max : w_sum[AMP_W-1:0];
      case (r_state)
         ST_ATTACK: w_div = c_attack_div;
         ST_DECAY:  w_div = c_decay_div;
         ST_MUTE:   w_div = c_mute_div;
         default:   w_div = c_attack_div;
      endcase
   end

   env_prescaler #(
      .CNT_W (CNT_W)
   ) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (w_clear),
      .div   (w_div),
      .tick  (w_tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_amp    <= '0;
         r_active <= 1'b0;
      end else if (w_pluck_ok) begin
         // Amplitude is kept so a re-strum does not click.
         r_state  <= ST_ATTACK;
         r_active <= 1'b1;
      end else if (w_to_mute) begin
         r_state  <= ST_MUTE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_amp <= '0;
            end
            ST_ATTACK: begin
               if (w_tick) begin
                  r_amp <= w_attack_amp;
                  if (w_attack_amp == c_amp_max) begin
                     r_state <= ST_DECAY;
                  end
               end
            end
            ST_DECAY: begin
               if (r_amp == '0) begin
                  r_state  <= ST_IDLE;
                  r_active <= 1'b0;
`ifdef PLUCK_ENVELOPE_SUSTAIN_EN
               end else if (r_amp <= c_sustain) begin
                  r_state <= ST_SUSTAIN;
`endif
               end else if (w_tick) begin
                  r_amp <= r_amp - c_amp_one;
                  if (r_amp == c_amp_one) begin
                     r_state  <= ST_IDLE;
                     r_active <= 1'b0;
                  end
               end
            end
            ST_MUTE: begin
               if (r_amp == '0) begin
                  r_state  <= ST_IDLE;
                  r_active <= 1'b0;
               end else if (w_tick) begin
                  r_amp <= r_amp - c_amp_one;
                  if (r_amp == c_amp_one) begin
                     r_state  <= ST_IDLE;
                     r_active <= 1'b0;
                  end
               end
            end
`ifdef PLUCK_ENVELOPE_SUSTAIN_EN
            ST_SUSTAIN: begin
               r_amp <= r_amp;
            end
`endif
            default: begin
               r_state  <= ST_IDLE;
               r_amp    <= '0;
               r_active <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pwm_cnt <= '0;
         r_audio   <= 1'b0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + c_amp_one;
         r_audio   <= wave_in && (r_pwm_cnt < r_amp);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pluck_envelope.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pluck_envelope                                                          |
// | Directed bench for pluck_envelope; sustain steps need PLUCK_ENVELOPE_SUSTAIN_EN. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pluck_envelope;

   logic       clk;
   logic       rst_n;
   logic       wave_in;
   logic [2:0] note_code;
   logic       pluck;
   logic       audio_out;
   logic [7:0] amplitude;
   logic       active;

   int n_total;
   int n_fail;

   logic [7:0] m_pwm;

   pluck_envelope #(
      .AMP_W       (8),
      .ATTACK_DIV  (2),
      .ATTACK_STEP (64),
      .DECAY_DIV   (4),
      .MUTE_DIV    (1)
`ifdef PLUCK_ENVELOPE_SUSTAIN_EN
      ,
      .SUSTAIN_LEVEL (64)
`endif
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wave_in   (wave_in),
      .note_code (note_code),
      .pluck     (pluck),
      .audio_out (audio_out),
      .amplitude (amplitude),
      .active    (active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference free-running PWM phase counter.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_pwm <= 8'd0;
      else        m_pwm <= m_pwm + 8'd1;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      n_total++;
      assert (obs === req) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
      end
   endtask

   task automatic pluck_once();
      pluck = 1'b1;
      step(1);
      pluck = 1'b0;
   endtask

   initial begin
      int highs;
      int mism;
      logic [7:0] prev_cnt;
      logic       req_bit;

      n_total   = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      wave_in   = 1'b0;
      note_code = 3'd7;
      pluck     = 1'b0;

      step(2);
      chk("reset_amp", 32'(amplitude), 0);
      chk("reset_audio", 32'(audio_out), 0);
      chk("reset_active", 32'(active), 0);
      rst_n = 1'b1;
      step(2);

      // Full pluck
      note_code = 3'd2;
      pluck_once();
      chk("pluck_active", 32'(active), 1);
      chk("pluck_amp0", 32'(amplitude), 0);
      step(2); chk("attack_64", 32'(amplitude), 64);
      step(2); chk("attack_128", 32'(amplitude), 128);
      step(2); chk("attack_192", 32'(amplitude), 192);
      step(2); chk("attack_255", 32'(amplitude), 255);
      step(4); chk("decay_254", 32'(amplitude), 254);
`ifdef PLUCK_ENVELOPE_SUSTAIN_EN
      step(760); chk("sustain_reach", 32'(amplitude), 64);
      step(20);
      chk("sustain_hold", 32'(amplitude), 64);
      chk("sustain_active", 32'(active), 1);
      note_code = 3'd7;
      step(1);
      step(63); chk("sus_mute_1", 32'(amplitude), 1);
      step(1);
      chk("sus_mute_0", 32'(amplitude), 0);
      chk("sus_mute_idle", 32'(active), 0);
`else
      step(1015);
      chk("decay_last1", 32'(amplitude), 1);
      chk("decay_active", 32'(active), 1);
      step(1);
      chk("decay_zero", 32'(amplitude), 0);
      chk("decay_idle", 32'(active), 0);
`endif

      // Ignored pluck
      note_code = 3'd7;
      pluck_once();
      step(2);
      chk("ignored_active", 32'(active), 0);
      chk("ignored_amp", 32'(amplitude), 0);

      // Re-pluck during decay
      note_code = 3'd2;
      pluck_once();
      step(228);
      chk("repluck_pre", 32'(amplitude), 200);
      pluck_once();
      chk("repluck_keep", 32'(amplitude), 200);
      step(1); chk("repluck_hold", 32'(amplitude), 200);
      step(1); chk("repluck_sat", 32'(amplitude), 255);

      // Mute
`ifdef PLUCK_ENVELOPE_SUSTAIN_EN
      note_code = 3'd7;
      step(1);
      step(255);
      chk("mute_zero", 32'(amplitude), 0);
      chk("mute_idle", 32'(active), 0);
`else
      step(820);
      chk("mute_pre50", 32'(amplitude), 50);
      note_code = 3'd7;
      step(1);
      chk("mute_entry", 32'(amplitude), 50);
      chk("mute_active", 32'(active), 1);
      step(49); chk("mute_1", 32'(amplitude), 1);
      step(1);
      chk("mute_zero", 32'(amplitude), 0);
      chk("mute_idle", 32'(active), 0);
`endif

      // Asynchronous reset mid-decay
      note_code = 3'd2;
      wave_in   = 1'b1;
      pluck_once();
      step(628);
      chk("prereset_amp", 32'(amplitude), 100);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_amp", 32'(amplitude), 0);
      chk("async_rst_audio", 32'(audio_out), 0);
      chk("async_rst_active", 32'(active), 0);
      step(1);
      rst_n     = 1'b1;
      note_code = 3'd7;
      wave_in   = 1'b0;
      step(2);

      // PWM at a fixed amplitude of 64
      force dut.r_amp = 8'd64;
      wave_in = 1'b1;
      highs = 0;
      mism  = 0;
      for (int i = 0; i < 256; i++) begin
         step(1);
         prev_cnt = m_pwm - 8'd1;
         req_bit  = (prev_cnt < 8'd64);
         if (audio_out !== req_bit) mism++;
         if (audio_out === 1'b1) highs++;
      end
      chk("pwm_phase_mism", 32'(mism), 0);
      chk("pwm_duty64", 32'(highs), 64);

      wave_in = 1'b0;
      step(1);
      highs = 0;
      for (int i = 0; i < 256; i++) begin
         step(1);
         if (audio_out !== 1'b0) highs++;
      end
      chk("pwm_wave0", 32'(highs), 0);

      release dut.r_amp;
      step(2);
      chk("pwm_release_amp", 32'(amplitude), 0);
      wave_in = 1'b1;
      step(1);
      highs = 0;
      for (int i = 0; i < 256; i++) begin
         step(1);
         if (audio_out !== 1'b0) highs++;
      end
      chk("pwm_amp0", 32'(highs), 0);

      $display("%0d/%0d checks passed", n_total - n_fail, n_total);
      $finish;
   end

endmodule
`default_nettype wire
